psr_cond_unit: RTL and testbench

PSR_COND_UNIT -- requirements
Module: psr_cond_unit

---
 rtl/psr_cond_unit.sv | 147 ++++++++++++++
 tb/tb_psr_cond_unit.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/psr_cond_unit.sv
// psr_cond_unit: ARM-style status register (N,Z,C,V) with ID-stage condition
// evaluation and a one-bubble flag-dependency interlock.
//
// Build option: define COND_FWD_EN to forward the EX-stage ALU flags into the
// condition evaluation. With forwarding enabled, the interlock never fires.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   alu_n/z/c/v           ALU flag results of the EX instruction
//   ex_valid, ex_s        EX holds a real instruction / it writes the flags
//   id_valid, id_cond     ID holds a real instruction / its condition field
//   stall                 global pipeline stall, freezes all state
//   flags                 status register {N,Z,C,V}
//   cin                   carry flag, ALU carry-in
//   cond_valid            registered: instruction entering EX is real
//   cond_pass             registered: instruction entering EX executes
//   hazard                combinational: hold upstream, insert a bubble
module psr_cond_unit (
  input  logic       clk,
  input  logic       reset,
  input  logic       alu_n,
  input  logic       alu_z,
  input  logic       alu_c,
  input  logic       alu_v,
  input  logic       ex_valid,
  input  logic       ex_s,
  input  logic       id_valid,
  input  logic [3:0] id_cond,
  input  logic       stall,
  output logic [3:0] flags,
  output logic       cin,
  output logic       cond_valid,
  output logic       cond_pass,
  output logic       hazard
);

  localparam int unsigned FLAG_W = 4;
  localparam int unsigned COND_W = 4;

  localparam logic [COND_W-1:0] COND_AL = 4'b1110;
  localparam logic [COND_W-1:0] COND_NV = 4'b1111;

  typedef enum logic {
    IDLE = 1'b0,
    HAZ  = 1'b1
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              cond_valid_nxt;
  logic              cond_pass_nxt;
  logic [FLAG_W-1:0] alu_flags;
  logic [FLAG_W-1:0] eff_flags;
  logic              flag_wr;
  logic              flag_dep;

  // ARM condition code evaluation against a {N,Z,C,V} flag vector
  function automatic logic cond_eval(input logic [COND_W-1:0] c,
                                     input logic [FLAG_W-1:0] f);
    logic n, z, cy, v;
    logic res;
    n   = f[3];
    z   = f[2];
    cy  = f[1];
    v   = f[0];
    res = 1'b0;
    case (c)
      4'b0000: res = z;
      4'b0001: res = ~z;
      4'b0010: res = cy;
      4'b0011: res = ~cy;
      4'b0100: res = n;
      4'b0101: res = ~n;
      4'b0110: res = v;
      4'b0111: res = ~v;
      4'b1000: res = cy & ~z;
      4'b1001: res = ~cy | z;
      4'b1010: res = (n == v);
      4'b1011: res = (n != v);
      4'b1100: res = ~z & (n == v);
      4'b1101: res = z | (n != v);
      4'b1110: res = 1'b1;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  assign alu_flags = {alu_n, alu_z, alu_c, alu_v};
  assign flag_wr   = ex_valid & ex_s;
  assign cin       = flags[1];

`ifdef COND_FWD_EN
  // Forwarded flags remove the dependency, so the interlock never fires
  assign eff_flags = flag_wr ? alu_flags : flags;
  assign flag_dep  = 1'b0;
`else
  // ID condition depends on flags still being produced in EX
  assign eff_flags = flags;
  assign flag_dep  = id_valid & flag_wr & (id_cond != COND_AL) & (id_cond != COND_NV);
`endif

  // Next-state, hazard and next registered-output logic
  always_comb begin
    state_nxt      = state;
    hazard         = 1'b0;
    cond_valid_nxt = id_valid;
    cond_pass_nxt  = id_valid & cond_eval(id_cond, eff_flags);

    case (state)
      IDLE: begin
        hazard = flag_dep & ~reset;
        if (hazard) begin
          state_nxt = HAZ;
        end
      end
      HAZ: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    if (hazard) begin
      cond_valid_nxt = 1'b0;
      cond_pass_nxt  = 1'b0;
    end
  end

  // State, status register and registered condition outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      flags      <= '0;
      cond_valid <= 1'b0;
      cond_pass  <= 1'b0;
    end else if (!stall) begin
      state      <= state_nxt;
      cond_valid <= cond_valid_nxt;
      cond_pass  <= cond_pass_nxt;
      if (flag_wr) begin
        flags <= alu_flags;
      end
    end
  end

endmodule

// File: tb/tb_psr_cond_unit.sv
// tb_psr_cond_unit: self-checking bench for psr_cond_unit.
// Table of condition vectors plus hand-written sequences for reset, the
// flag-dependency bubble and stall. Expected outputs are queued at drive
// time and compared after the clock edge. Honours COND_FWD_EN.
module tb_psr_cond_unit;

`ifdef COND_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  // Expected hazard level whenever a real flag dependency is presented in IDLE
  localparam logic DEP_HAZ = ~FWD;

  logic       clk;
  logic       reset;
  logic       alu_n, alu_z, alu_c, alu_v;
  logic       ex_valid, ex_s, id_valid, stall;
  logic [3:0] id_cond;
  logic [3:0] flags;
  logic       cin, cond_valid, cond_pass, hazard;

  psr_cond_unit dut (
    .clk       (clk),
    .reset     (reset),
    .alu_n     (alu_n),
    .alu_z     (alu_z),
    .alu_c     (alu_c),
    .alu_v     (alu_v),
    .ex_valid  (ex_valid),
    .ex_s      (ex_s),
    .id_valid  (id_valid),
    .id_cond   (id_cond),
    .stall     (stall),
    .flags     (flags),
    .cin       (cin),
    .cond_valid(cond_valid),
    .cond_pass (cond_pass),
    .hazard    (hazard)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] fl;
    logic       iv;
    logic [3:0] cond;
    logic       cv;
    logic       cp;
  } vec_t;

  typedef struct {
    string      name;
    logic [3:0] fl;
    logic       cv;
    logic       cp;
  } exp_t;

  exp_t sbq[$];
  int   tests  = 0;
  int   failed = 0;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_haz(input string name, input logic exp);
    #1;
    chk({name, ".hazard"}, {3'b000, hazard}, {3'b000, exp});
  endtask

  task automatic drive(input logic ev, input logic es, input logic [3:0] alu,
                       input logic iv, input logic [3:0] cond, input logic st);
    ex_valid = ev;
    ex_s     = es;
    {alu_n, alu_z, alu_c, alu_v} = alu;
    id_valid = iv;
    id_cond  = cond;
    stall    = st;
  endtask

  // Queue the expectation, clock once, then pop and compare
  task automatic tick(input string name, input logic [3:0] fl, input logic cv, input logic cp);
    exp_t e;
    e.name = name;
    e.fl   = fl;
    e.cv   = cv;
    e.cp   = cp;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    if (sbq.size() == 0) begin
      tests++;
      failed++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = sbq.pop_front();
      chk({e.name, ".flags"}, flags, e.fl);
      chk({e.name, ".cin"}, {3'b000, cin}, {3'b000, e.fl[1]});
      chk({e.name, ".cond_valid"}, {3'b000, cond_valid}, {3'b000, e.cv});
      chk({e.name, ".cond_pass"}, {3'b000, cond_pass}, {3'b000, e.cp});
    end
  endtask

  task automatic chk_regs(input string name, input logic [3:0] fl, input logic cv, input logic cp);
    chk({name, ".flags"}, flags, fl);
    chk({name, ".cin"}, {3'b000, cin}, {3'b000, fl[1]});
    chk({name, ".cond_valid"}, {3'b000, cond_valid}, {3'b000, cv});
    chk({name, ".cond_pass"}, {3'b000, cond_pass}, {3'b000, cp});
  endtask

  // Asynchronous reset pulse placed away from any clock edge
  task automatic pulse_reset();
    #2;
    reset = 1'b1;
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[$];

    vecs = '{
      '{4'b1001, 1'b1, 4'b1010, 1'b1, 1'b1},  // GE
      '{4'b1001, 1'b1, 4'b1011, 1'b1, 1'b0},  // LT
      '{4'b1001, 1'b1, 4'b1100, 1'b1, 1'b1},  // GT
      '{4'b1001, 1'b1, 4'b1101, 1'b1, 1'b0},  // LE
      '{4'b1001, 1'b1, 4'b1111, 1'b1, 1'b0},  // NV
      '{4'b0100, 1'b1, 4'b0000, 1'b1, 1'b1},  // EQ
      '{4'b0100, 1'b1, 4'b0001, 1'b1, 1'b0},  // NE
      '{4'b0100, 1'b1, 4'b1000, 1'b1, 1'b0},  // HI
      '{4'b0100, 1'b1, 4'b1001, 1'b1, 1'b1},  // LS
      '{4'b0100, 1'b1, 4'b1100, 1'b1, 1'b0},  // GT
      '{4'b0010, 1'b1, 4'b0010, 1'b1, 1'b1},  // CS
      '{4'b0010, 1'b1, 4'b0011, 1'b1, 1'b0},  // CC
      '{4'b0010, 1'b1, 4'b1000, 1'b1, 1'b1},  // HI
      '{4'b0010, 1'b1, 4'b1001, 1'b1, 1'b0},  // LS
      '{4'b1000, 1'b1, 4'b0100, 1'b1, 1'b1},  // MI
      '{4'b1000, 1'b1, 4'b0101, 1'b1, 1'b0},  // PL
      '{4'b1000, 1'b1, 4'b1010, 1'b1, 1'b0},  // GE
      '{4'b1000, 1'b1, 4'b1011, 1'b1, 1'b1},  // LT
      '{4'b0001, 1'b1, 4'b0110, 1'b1, 1'b1},  // VS
      '{4'b0001, 1'b1, 4'b0111, 1'b1, 1'b0},  // VC
      '{4'b0001, 1'b1, 4'b1101, 1'b1, 1'b1},  // LE
      '{4'b0000, 1'b1, 4'b1110, 1'b1, 1'b1},  // AL
      '{4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0},  // EQ
      '{4'b0000, 1'b1, 4'b0011, 1'b1, 1'b1},  // CC
      '{4'b0000, 1'b1, 4'b1100, 1'b1, 1'b1},  // GT
      '{4'b1111, 1'b0, 4'b1110, 1'b0, 1'b0}   // AL but ID empty
    };

    reset = 1'b1;
    drive(1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0);
    #1;
    chk_regs("por", 4'b0000, 1'b0, 1'b0);
    chk_haz("por", 1'b0);
    #10;
    reset = 1'b0;

    // Reset from flags=1111 with cond_valid set and a dependency presented
    drive(1'b1, 1'b1, 4'b1111, 1'b1, 4'b1110, 1'b0);
    chk_haz("pre_rst_al", 1'b0);
    tick("pre_rst", 4'b1111, 1'b1, 1'b1);
    drive(1'b1, 1'b1, 4'b1111, 1'b1, 4'b0000, 1'b0);
    chk_haz("pre_rst_dep", DEP_HAZ);
    #1;
    reset = 1'b1;
    #1;
    chk_regs("rst_async", 4'b0000, 1'b0, 1'b0);
    chk_haz("rst_async", 1'b0);
    reset = 1'b0;

    // Load flags N=0 Z=1 C=1 V=0, then EQ consumes them
    drive(1'b1, 1'b1, 4'b0110, 1'b0, 4'b0000, 1'b0);
    tick("load_0110", 4'b0110, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0);
    chk_haz("eq_no_s", 1'b0);
    tick("eq_after_load", 4'b0110, 1'b1, 1'b1);

    // Flag dependency: bubble then execute (no bubble when forwarding)
    pulse_reset();
    drive(1'b1, 1'b1, 4'b0100, 1'b1, 4'b0000, 1'b0);
    chk_haz("dep_idle", DEP_HAZ);
    tick("dep_edge1", 4'b0100, FWD, FWD);
    chk_haz("dep_haz_state", 1'b0);
    tick("dep_edge2", 4'b0100, 1'b1, 1'b1);
    chk_haz("dep_back_idle", DEP_HAZ);

    // Reset while in HAZ: first edge afterwards behaves as IDLE
    pulse_reset();
    drive(1'b1, 1'b1, 4'b0100, 1'b1, 4'b0000, 1'b0);
    chk_haz("rh_idle", DEP_HAZ);
    tick("rh_edge1", 4'b0100, FWD, FWD);
    chk_haz("rh_in_haz", 1'b0);
    #1;
    reset = 1'b1;
    #1;
    chk_regs("rh_rst", 4'b0000, 1'b0, 1'b0);
    reset = 1'b0;
    chk_haz("rh_post_rst", DEP_HAZ);
    tick("rh_edge2", 4'b0100, FWD, FWD);

    // Stall while in HAZ (non-forwarding) and then while in IDLE
    pulse_reset();
    drive(1'b1, 1'b1, 4'b1000, 1'b1, 4'b0100, 1'b0);
    chk_haz("st_dep", DEP_HAZ);
    tick("st_enter", 4'b1000, FWD, FWD);
    drive(1'b1, 1'b1, 4'b0110, 1'b1, 4'b0100, 1'b1);
    chk_haz("st_haz", 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick($sformatf("st_hold_a%0d", i), 4'b1000, FWD, FWD);
    end
    drive(1'b1, 1'b1, 4'b0110, 1'b1, 4'b0100, 1'b0);
    chk_haz("st_release", 1'b0);
    // MI sees stored N=1 without forwarding, forwarded N=0 with it
    tick("st_release", 4'b0110, 1'b1, ~FWD);
    drive(1'b1, 1'b1, 4'b1001, 1'b1, 4'b0100, 1'b1);
    chk_haz("st_idle_dep", DEP_HAZ);
    id_valid = 1'b0;
    chk_haz("st_idle_noid", 1'b0);
    id_valid = 1'b1;
    chk_haz("st_idle_dep2", DEP_HAZ);
    for (int i = 0; i < 3; i++) begin
      tick($sformatf("st_hold_b%0d", i), 4'b0110, 1'b1, ~FWD);
      chk_haz($sformatf("st_hold_b%0d", i), DEP_HAZ);
    end

    // Condition table: load flags, then evaluate with no flag write in EX
    pulse_reset();
    foreach (vecs[i]) begin
      drive(1'b1, 1'b1, vecs[i].fl, 1'b0, 4'b0000, 1'b0);
      tick($sformatf("vec%0d_load", i), vecs[i].fl, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 4'b0000, vecs[i].iv, vecs[i].cond, 1'b0);
      chk_haz($sformatf("vec%0d", i), 1'b0);
      tick($sformatf("vec%0d_cond%b", i, vecs[i].cond), vecs[i].fl, vecs[i].cv, vecs[i].cp);
    end

    if (sbq.size() != 0) begin
      tests++;
      failed++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sbq.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
